// File: rtl/vec_gather.sv
// Strided gather engine: reads up to VEC_BUFFER_LEN words through a 1-cycle
// synchronous memory port and packs them into a flat vector for the VPU.
module vec_gather #(
    parameter int unsigned NUM_SIZE        = 16,
    parameter int unsigned VEC_BUFFER_LEN  = 8,
    parameter int unsigned WORDS_IN_MEMORY = 32,
    parameter int unsigned ADDR_LEN        = $clog2(WORDS_IN_MEMORY),
    parameter int unsigned LEN_W           = $clog2(VEC_BUFFER_LEN) + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [ADDR_LEN-1:0]                base_addr,
    input  logic [ADDR_LEN-1:0]                stride,
    input  logic [LEN_W-1:0]                   length,
    output logic                               busy,
    output logic                               mem_rd_en,
    output logic [ADDR_LEN-1:0]                mem_rd_addr,
    input  logic [NUM_SIZE-1:0]                mem_rd_data,
    output logic [NUM_SIZE*VEC_BUFFER_LEN-1:0] flat_vec_out,
    output logic                               vec_valid
);

    localparam int unsigned IDX_W = $clog2(VEC_BUFFER_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;
    logic [LEN_W-1:0]      w_eff_len;

    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_issued;
    logic [ADDR_LEN-1:0]   r_stride;
    logic [ADDR_LEN-1:0]   r_next_addr;
    logic                  r_rd_en;
    logic [ADDR_LEN-1:0]   r_rd_addr;
    logic                  r_cap_en;
    logic [IDX_W-1:0]      r_cap_idx;
    logic [NUM_SIZE-1:0]   r_slot [VEC_BUFFER_LEN];
    logic                  r_busy;
    logic                  r_vec_valid;

    // Oversize requests are clamped to the vector length.
    always_comb begin
        w_eff_len = length;
        if (length > LEN_W'(VEC_BUFFER_LEN)) begin
            w_eff_len = LEN_W'(VEC_BUFFER_LEN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A zero-length request passes through DRAIN so vec_valid keeps the same
    // two-edge tail as a real gather.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = (w_eff_len != '0) ? S_ISSUE : S_DRAIN;
                end
            end
            S_ISSUE: begin
                if (r_issued == r_len) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Issue pipeline: the read for element i is presented in the cycle after
    // edge i; r_issued counts reads already presented on the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_issued    <= '0;
            r_stride    <= '0;
            r_next_addr <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_busy      <= 1'b0;
            r_vec_valid <= 1'b0;
        end else begin
            r_busy      <= (w_state_next != S_IDLE);
            r_vec_valid <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_len    <= w_eff_len;
                r_stride <= stride;
                r_rd_en  <= (w_eff_len != '0);
                r_issued <= (w_eff_len != '0) ? LEN_W'(1) : '0;
                if (w_eff_len != '0) begin
                    r_rd_addr   <= base_addr;
                    r_next_addr <= base_addr + stride;
                end
            end else if (r_state == S_ISSUE && r_issued != r_len) begin
                r_rd_en     <= 1'b1;
                r_rd_addr   <= r_next_addr;
                r_next_addr <= r_next_addr + r_stride;
                r_issued    <= r_issued + LEN_W'(1);
            end else begin
                r_rd_en <= 1'b0;
            end
        end
    end

    // Capture: data returns the cycle after a read, so captures trail reads by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_en  <= 1'b0;
            r_cap_idx <= '0;
            for (int i = 0; i < int'(VEC_BUFFER_LEN); i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_cap_en <= r_rd_en;
            if (w_accept) begin
                r_cap_idx <= '0;
                for (int i = 0; i < int'(VEC_BUFFER_LEN); i++) begin
                    r_slot[i] <= '0;
                end
            end else if (r_cap_en) begin
                r_slot[r_cap_idx] <= mem_rd_data;
                r_cap_idx         <= r_cap_idx + IDX_W'(1);
            end
        end
    end

    for (genvar g = 0; g < int'(VEC_BUFFER_LEN); g++) begin : g_flat
        assign flat_vec_out[g*NUM_SIZE +: NUM_SIZE] = r_slot[g];
    end

    assign busy        = r_busy;
    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign vec_valid   = r_vec_valid;

endmodule
